sync_ram: RTL and testbench

//   Single-port synchronous RAM: DATA_WIDTH-bit words, 2**ADDR_WIDTH deep, one clock.

---
 rtl/sync_ram_pkg.sv | 9 +
 rtl/sync_ram_array.sv | 37 +++
 rtl/sync_ram.sv | 74 +++++++
 tb/tb_sync_ram.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// Shared defaults and types for the sync_ram storage block.
package sync_ram_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] ram_word_t;

endpackage : sync_ram_pkg

// File: rtl/sync_ram_array.sv
// Bare storage array for sync_ram: one synchronous write port and one
// asynchronous read port, with no reset on the contents.
// The parent registers the read data, so the pair maps onto a block RAM.
// Ports:
//   clk      rising-edge clock
//   we_i     write enable: mem[addr_i] <= wdata_i at posedge clk
//   addr_i   word address, shared by the read and write ports
//   wdata_i  write data
//   rdata_c  read data for addr_i (combinational)
module sync_ram_array
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port; returns the contents from before this cycle's write.
  assign rdata_c = mem_q[addr_i];

endmodule : sync_ram_array

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered, 1-cycle read.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears Dout only)
//   Din      write data
//   addr     word address, shared by read and write
//   writeEn  write strobe: mem[addr] <= Din at posedge clk
//   read     read strobe: Dout <= mem[addr] at posedge clk
//   Dout     registered read data, holds between reads
// Build option: SYNC_RAM_WR_FWD_EN
//   defined   -> write-first (a same-cycle read+write returns Din)
//   undefined -> read-first  (a same-cycle read+write returns the old word)
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  writeEn,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] Dout
);

  logic                  we_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  // The array itself has no reset, so block writes here while reset is held.
  assign we_c = writeEn & rst_n;

  sync_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk    (clk),
    .we_i   (we_c),
    .addr_i (addr),
    .wdata_i(Din),
    .rdata_c(rdata_c)
  );

  // Collision policy for a same-cycle read and write.
`ifdef SYNC_RAM_WR_FWD_EN
  assign rd_word_c = writeEn ? Din : rdata_c;
`else
  assign rd_word_c = rdata_c;
`endif

  // Dout next-state: load on read, otherwise hold.
  always_comb begin
    dout_d = dout_q;
    if (read) begin
      dout_d = rd_word_c;
    end
  end

  // Dout register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign Dout = dout_q;

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: fill/readback sweep, a vector table for
// hold, disabled-write, collision and boundary cases, a hand-written reset
// sequence, then random traffic against a simple array model.
module tb_sync_ram;
  import sync_ram_pkg::*;

  localparam int unsigned AW    = DEFAULT_ADDR_WIDTH;
  localparam int unsigned DW    = DEFAULT_DATA_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;

`ifdef SYNC_RAM_WR_FWD_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  ram_word_t     din;
  logic [AW-1:0] addr;
  logic          write_en;
  logic          rd;
  ram_word_t     dout;

  sync_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Din    (din),
    .addr   (addr),
    .writeEn(write_en),
    .read   (rd),
    .Dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the RAM holds and what the output should show.
  ram_word_t model_mem [DEPTH];
  ram_word_t exp_dout;

  typedef struct {
    bit        we;
    bit        re;
    int        a;
    ram_word_t d;
    ram_word_t exp;
    string     name;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input ram_word_t act, input ram_word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: Dout=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Entered just after a falling edge: drive, clock once, update the model,
  // then leave just after the next falling edge with Dout observable.
  task automatic step(input bit we, input bit re, input int a, input ram_word_t d);
    write_en = we;
    rd       = re;
    addr     = AW'(a);
    din      = d;
    @(posedge clk);
    if (rst_n) begin
      if (re) exp_dout = (we && WRITE_FIRST) ? d : model_mem[a];
      if (we) model_mem[a] = d;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    write_en = 1'b0;
    rd       = 1'b0;
    addr     = '0;
    din      = '0;
    exp_dout = '0;

    repeat (2) @(negedge clk);
    check("reset_state", dout, 32'h0);
    rst_n = 1'b1;

    // Fill: mem[i] = 2*i+1, Dout must stay at 0 with no reads.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, i, 32'(2 * i + 1));
    check("fill_no_read", dout, 32'h0);

    // Readback sweep.
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(1'b0, 1'b1, i, 32'h0);
      check($sformatf("readback_%0d", i), dout, 32'(2 * i + 1));
    end

    // Table: hold, disabled write, collision, boundary.
    tbl[0]  = '{1'b0, 1'b1, 5,    32'h0,        32'd11, "read_5"};
    tbl[1]  = '{1'b0, 1'b0, 7,    32'h0,        32'd11, "hold_1"};
    tbl[2]  = '{1'b0, 1'b0, 7,    32'h0,        32'd11, "hold_2"};
    tbl[3]  = '{1'b0, 1'b0, 7,    32'h0,        32'd11, "hold_3"};
    tbl[4]  = '{1'b0, 1'b0, 3,    32'hDEADBEEF, 32'd11, "we0_no_read"};
    tbl[5]  = '{1'b0, 1'b1, 3,    32'h0,        32'd7,  "we0_unchanged"};
    tbl[6]  = '{1'b1, 1'b1, 4,    32'h1234,     WRITE_FIRST ? 32'h1234 : 32'd9, "collision"};
    tbl[7]  = '{1'b0, 1'b1, 4,    32'h0,        32'h1234, "post_collision"};
    tbl[8]  = '{1'b1, 1'b0, 1023, 32'hFFFFFFFF, 32'h1234, "wr_top"};
    tbl[9]  = '{1'b1, 1'b0, 0,    32'h0,        32'h1234, "wr_bottom"};
    tbl[10] = '{1'b0, 1'b1, 1023, 32'h0,        32'hFFFFFFFF, "rd_top"};
    tbl[11] = '{1'b0, 1'b1, 0,    32'h0,        32'h0,  "rd_bottom"};
    tbl[12] = '{1'b0, 1'b1, 1022, 32'h0,        32'd2045, "neighbour_top"};
    tbl[13] = '{1'b0, 1'b1, 1,    32'h0,        32'd3,  "neighbour_bottom"};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d);
      check(tbl[i].name, dout, tbl[i].exp);
    end

    // Reset mid-cycle: Dout clears without a clock edge, accesses are ignored.
    #2 rst_n = 1'b0;
    #1 check("reset_async", dout, 32'h0);
    write_en = 1'b1;
    rd       = 1'b1;
    addr     = AW'(10);
    din      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 check("reset_hold", dout, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_dout = '0;
    step(1'b0, 1'b1, 10, 32'h0);
    check("reset_contents", dout, 32'd21);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH - 1)), ram_word_t'($urandom));
      check($sformatf("random_%0d", n), dout, exp_dout);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_ram
